// File: rtl/jstk2_pkg.sv
// Shared constants and types for the JSTK2 SPI joystick masters and the responder.
// Frame layout helper: X, Y and button bytes as the joystick reports them.
package jstk2_pkg;

  localparam int FRAME_BYTES_DEF = 5;
  localparam int JSTK_BITS       = 40;
  localparam logic [7:0] CMD_SET_LED = 8'h84;

  // Byte positions within the transmit frame
  localparam int BYTE_X_LO = 0;
  localparam int BYTE_X_HI = 1;
  localparam int BYTE_Y_LO = 2;
  localparam int BYTE_Y_HI = 3;
  localparam int BYTE_BTN  = 4;

  // Byte positions within the received set-LED command
  localparam int BYTE_CMD   = 0;
  localparam int BYTE_LED_R = 1;
  localparam int BYTE_LED_G = 2;
  localparam int BYTE_LED_B = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, END} state_t;

  function automatic logic [JSTK_BITS-1:0] build_frame(input logic [9:0] x,
                                                       input logic [9:0] y,
                                                       input logic [1:0] btn);
    logic [JSTK_BITS-1:0] f;
    f = '0;
    f[JSTK_BITS-1-8*BYTE_X_LO -: 8] = x[7:0];
    f[JSTK_BITS-1-8*BYTE_X_HI -: 8] = {6'b0, x[9:8]};
    f[JSTK_BITS-1-8*BYTE_Y_LO -: 8] = y[7:0];
    f[JSTK_BITS-1-8*BYTE_Y_HI -: 8] = {6'b0, y[9:8]};
    f[JSTK_BITS-1-8*BYTE_BTN  -: 8] = {6'b0, btn};
    return f;
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI pin bundle between a JSTK2 master and the responder.
interface jstk2_spi_responder_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS, output MOSI, input MISO);
  modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 0 so a pin already low when reset releases never looks like a fresh falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2 emulator: SPI mode-0 slave reporting X/Y/buttons and decoding set-LED.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  jstk2_spi_responder_if.slave  spi,
  input  logic [9:0]            x_pos,
  input  logic [9:0]            y_pos,
  input  logic [1:0]            buttons,
  output logic [23:0]           led_rgb,
  output logic                  led_valid,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int FRAME_BITS = FRAME_BYTES * 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int RX_BITS    = 8 * (BYTE_LED_B + 1);

  state_t                 state, state_nxt;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s, ss_pend, start, cnt_full, is_led_cmd, miso_d;
  logic [FRAME_BITS-1:0]  tx_sr, tx_load;
  logic [RX_BITS-1:0]     rx_sr;
  logic [CNT_W-1:0]       bit_cnt;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .din(spi.SCLK), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst(rst), .din(spi.SS), .rise(ss_rise), .fall(ss_fall));

  assign mosi_s     = mosi_q[SYNC_STAGES-1];
  assign start      = ss_fall | ss_pend;
  assign cnt_full   = (bit_cnt == CNT_W'(FRAME_BITS));
  assign is_led_cmd = (rx_sr[RX_BITS-1-8*BYTE_CMD -: 8] == CMD_SET_LED);

  always_comb begin
    tx_load = '0;
    tx_load[FRAME_BITS-1 -: JSTK_BITS] = build_frame(x_pos, y_pos, buttons);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = END;
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    miso_d     = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    led_valid  = 1'b0;
    case (state)
      SHIFT:   miso_d = tx_sr[FRAME_BITS-1];
      END: begin
        if (cnt_full) begin
          frame_done = 1'b1;
          led_valid  = is_led_cmd;
        end else begin
          frame_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign spi.MISO = miso_d;

  // SCLK edges are applied even in the cycle SS rises, so a late last bit still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q  <= '0;
      ss_pend <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      led_rgb <= '0;
    end else begin
      mosi_q  <= {mosi_q[SYNC_STAGES-2:0], spi.MOSI};
      ss_pend <= (state == END) && ss_fall;
      case (state)
        IDLE: if (start) begin
          tx_sr   <= tx_load;
          rx_sr   <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (sclk_rise && !cnt_full) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt < CNT_W'(RX_BITS)) rx_sr <= {rx_sr[RX_BITS-2:0], mosi_s};
          end
          if (sclk_fall) tx_sr <= tx_sr << 1;
        end
        END: if (cnt_full && is_led_cmd)
          led_rgb <= {rx_sr[RX_BITS-1-8*BYTE_LED_R -: 8],
                      rx_sr[RX_BITS-1-8*BYTE_LED_G -: 8],
                      rx_sr[RX_BITS-1-8*BYTE_LED_B -: 8]};
        default: ;
      endcase
    end
  end

endmodule
